// File: rtl/split_merge_pkg.sv
// Layout helpers shared by the head-merge and head-split stages so both
// agree on how head-group slices are packed into the merged matrix.
package split_merge_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } split_state_e;

    function automatic int count_max(input int head_num, input int head_group);
        return head_num / head_group;
    endfunction

    function automatic int slice_w(input int data_width, input int seq_len,
                                   input int head_group, input int head_dim);
        return data_width * seq_len * head_group * head_dim;
    endfunction

    function automatic int full_w(input int data_width, input int seq_len,
                                  input int head_num, input int head_dim);
        return data_width * seq_len * head_num * head_dim;
    endfunction

    // Slice counter width; a single-slice configuration still keeps one bit.
    function automatic int cnt_w(input int cmax);
        return (cmax > 1) ? $clog2(cmax) : 1;
    endfunction

endpackage

// File: rtl/split_slice_mux.sv
// Selects head-group slice `sel` out of the full merged buffer.
module split_slice_mux #(
    parameter int SLICE_W   = 64,
    parameter int COUNT_MAX = 3,
    parameter int CNT_W     = 2
) (
    input  logic [SLICE_W*COUNT_MAX-1:0] buffer,
    input  logic [CNT_W-1:0]             sel,
    output logic [SLICE_W-1:0]           slice
);

    assign slice = buffer[int'(sel) * SLICE_W +: SLICE_W];

endmodule

// File: rtl/split_method1.sv
// Head-split stage: captures one merged matrix and replays it as
// COUNT_MAX head-group slices tagged with their index.
module split_method1
    import split_merge_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SEQ_LEN    = 128,
    parameter int HEAD_GROUP = 4,
    parameter int HEAD_DIM   = 64,
    parameter int HEAD_NUM   = 12,
    parameter int NUM_WIDTH  = 3,
    localparam int FULL_W    = full_w(DATA_WIDTH, SEQ_LEN, HEAD_NUM, HEAD_DIM),
    localparam int SLICE_W   = slice_w(DATA_WIDTH, SEQ_LEN, HEAD_GROUP, HEAD_DIM)
) (
    input  logic                 clk_p,
    input  logic                 rst_n,
    input  logic [FULL_W-1:0]    matrix,
    input  logic                 input_valid_n,
    output logic                 input_ready,
    input  logic                 downstream_ready_n,
    output logic [SLICE_W-1:0]   split_matrix,
    output logic [NUM_WIDTH:0]   num,
    output logic                 output_valid_n,
    output logic                 output_last,
    output split_state_e         dbg_state
);

    localparam int COUNT_MAX = count_max(HEAD_NUM, HEAD_GROUP);
    localparam int CNT_W     = cnt_w(COUNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX - 1);

    if (HEAD_NUM % HEAD_GROUP != 0) begin : g_bad_group
        $fatal(1, "split_method1: HEAD_NUM must be a multiple of HEAD_GROUP");
    end
    if (COUNT_MAX < 1) begin : g_bad_count
        $fatal(1, "split_method1: COUNT_MAX must be at least 1");
    end
    if (COUNT_MAX > 2 ** (NUM_WIDTH + 1)) begin : g_bad_num
        $fatal(1, "split_method1: num is too narrow for COUNT_MAX");
    end

    // Handshake: a matrix is taken on an edge where input_ready=1 and
    // input_valid_n=0; a slice moves on an edge where output_valid_n=0 and
    // downstream_ready_n=0. A presented slice holds, valid, until it moves.
    split_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FULL_W-1:0] buffer_q;
    logic              load_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (!input_valid_n) begin
                    load_en = 1'b1;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!downstream_ready_n) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_p) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            buffer_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_en) begin
                buffer_q <= matrix;
            end
        end
    end

    // Every output decodes registered state only, so no input reaches them.
    split_slice_mux #(
        .SLICE_W   (SLICE_W),
        .COUNT_MAX (COUNT_MAX),
        .CNT_W     (CNT_W)
    ) u_slice_mux (
        .buffer (buffer_q),
        .sel    (cnt_q),
        .slice  (split_matrix)
    );

    assign input_ready    = (state_q == IDLE);
    assign output_valid_n = (state_q != SEND);
    assign output_last    = (state_q == SEND) && (cnt_q == CNT_LAST);
    assign num            = (NUM_WIDTH + 1)'(cnt_q);
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_split_method1.sv
// Bench for split_method1: scoreboarded slice replay, stalls, ignored input,
// back-to-back matrices, mid-split reset and slice reassembly.
module tb_split_method1;
    import split_merge_pkg::*;

    localparam int SW = 64;
    localparam int FW = 192;
    localparam int CM = 3;
    localparam int EW = 69;

    logic          clk_p = 1'b0;
    logic          rst_n;
    logic [FW-1:0] matrix;
    logic          input_valid_n;
    logic          input_ready;
    logic          downstream_ready_n;
    logic [SW-1:0] split_matrix;
    logic [3:0]    num;
    logic          output_valid_n;
    logic          output_last;
    split_state_e  dbg_state;

    logic [EW-1:0] exp_q[$];
    logic [FW-1:0] mat_q[$];
    int            total = 0;
    int            bad = 0;

    logic          last_xfer_d = 1'b0;
    logic          stall_d = 1'b0;
    logic [3:0]    hold_num;
    logic [SW-1:0] hold_slice;
    logic [FW-1:0] merged = '0;
    logic [EW-1:0] ent;
    logic          rand_on = 1'b0;

    split_method1 #(
        .DATA_WIDTH (8),
        .SEQ_LEN    (2),
        .HEAD_GROUP (2),
        .HEAD_DIM   (2),
        .HEAD_NUM   (6),
        .NUM_WIDTH  (3)
    ) dut (
        .clk_p              (clk_p),
        .rst_n              (rst_n),
        .matrix             (matrix),
        .input_valid_n      (input_valid_n),
        .input_ready        (input_ready),
        .downstream_ready_n (downstream_ready_n),
        .split_matrix       (split_matrix),
        .num                (num),
        .output_valid_n     (output_valid_n),
        .output_last        (output_last),
        .dbg_state          (dbg_state)
    );

    always #5 clk_p = ~clk_p;

    task automatic check_val(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic [3:0] base);
        logic [FW-1:0] m;
        m = '0;
        for (int k = 0; k < CM; k++) m[k*SW +: SW] = {16{base + 4'(k)}};
        return m;
    endfunction

    function automatic logic [FW-1:0] rand_mat();
        logic [FW-1:0] m;
        m = '0;
        for (int k = 0; k < FW / 32; k++) m[k*32 +: 32] = $urandom;
        return m;
    endfunction

    // Monitor: samples on the falling edge, acting on what the next rising edge does.
    always @(negedge clk_p) begin
        if (rst_n) begin
            if (last_xfer_d) begin
                check_val("gap_valid_n", FW'(output_valid_n), FW'(1));
                check_val("gap_input_ready", FW'(input_ready), FW'(1));
            end
            last_xfer_d = 1'b0;
            if (stall_d) begin
                check_val("stall_valid_n", FW'(output_valid_n), FW'(0));
                check_val("stall_num", FW'(num), FW'(hold_num));
                check_val("stall_slice", FW'(split_matrix), FW'(hold_slice));
            end
            stall_d = 1'b0;
            if (input_ready && !input_valid_n) begin
                for (int k = 0; k < CM; k++)
                    exp_q.push_back({4'(k), (k == CM - 1), matrix[k*SW +: SW]});
                mat_q.push_back(matrix);
            end
            if (!output_valid_n) begin
                check_val("send_input_ready", FW'(input_ready), FW'(0));
                if (!downstream_ready_n) begin
                    check_val("slice_expected", FW'(exp_q.size() != 0), FW'(1));
                    if (exp_q.size() != 0) begin
                        ent = exp_q.pop_front();
                        check_val("slice", FW'({num, output_last, split_matrix}), FW'(ent));
                    end
                    merged[int'(num)*SW +: SW] = split_matrix;
                    if (output_last) begin
                        last_xfer_d = 1'b1;
                        if (mat_q.size() != 0) check_val("round_trip", merged, mat_q.pop_front());
                    end
                end else begin
                    stall_d    = 1'b1;
                    hold_num   = num;
                    hold_slice = split_matrix;
                end
            end
        end
    end

    task automatic send_matrix(input logic [FW-1:0] m);
        int n;
        n = 0;
        @(posedge clk_p); #1;
        matrix = m;
        input_valid_n = 1'b0;
        @(negedge clk_p);
        while (!input_ready && n < 50) begin
            @(negedge clk_p);
            n++;
        end
        if (!input_ready) check_val("accept_timeout", FW'(0), FW'(1));
        @(posedge clk_p); #1;
        input_valid_n = 1'b1;
    endtask

    task automatic wait_ready_neg();
        int n;
        n = 0;
        @(negedge clk_p);
        while (!input_ready && n < 50) begin
            @(negedge clk_p);
            n++;
        end
        if (!input_ready) check_val("ready_timeout", FW'(0), FW'(1));
    endtask

    task automatic wait_num(input int k);
        int  n;
        logic found;
        n = 0;
        found = 1'b0;
        while (!found && n < 50) begin
            @(posedge clk_p); #1;
            n++;
            found = !output_valid_n && (int'(num) == k);
        end
        if (!found) check_val("wait_num_timeout", FW'(0), FW'(1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk_p);
        while ((exp_q.size() != 0 || !output_valid_n) && n < 300) begin
            @(negedge clk_p);
            n++;
        end
        check_val("drain_queue", FW'(exp_q.size()), FW'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        input_valid_n = 1'b1;
        downstream_ready_n = 1'b0;
        matrix = '0;
        repeat (3) @(posedge clk_p);
        #1;
        check_val("rst_valid_n", FW'(output_valid_n), FW'(1));
        check_val("rst_num", FW'(num), FW'(0));
        check_val("rst_slice", FW'(split_matrix), FW'(0));
        check_val("rst_last", FW'(output_last), FW'(0));
        check_val("rst_input_ready", FW'(input_ready), FW'(1));
        check_val("rst_state", FW'(dbg_state), FW'(IDLE));
        rst_n = 1'b1;

        // Basic replay with the consumer always ready.
        send_matrix(mk(4'h0));
        wait_idle();
        check_val("basic_idle_ready", FW'(input_ready), FW'(1));
        check_val("basic_idle_valid_n", FW'(output_valid_n), FW'(1));

        // Four-cycle stall on slice 1.
        send_matrix(mk(4'h3));
        wait_num(1);
        downstream_ready_n = 1'b1;
        repeat (4) @(posedge clk_p);
        #1;
        downstream_ready_n = 1'b0;
        wait_idle();

        // New matrix offered mid-split must be ignored.
        send_matrix(mk(4'h6));
        wait_num(1);
        matrix = mk(4'h9);
        input_valid_n = 1'b0;
        @(posedge clk_p); #1;
        input_valid_n = 1'b1;
        wait_idle();

        // Back-to-back matrices with input valid held low throughout.
        @(posedge clk_p); #1;
        matrix = mk(4'hA);
        input_valid_n = 1'b0;
        wait_ready_neg();
        @(posedge clk_p); #1;
        matrix = mk(4'hC);
        wait_ready_neg();
        @(posedge clk_p); #1;
        input_valid_n = 1'b1;
        wait_idle();

        // Reset while slice 1 is presented aborts the split.
        send_matrix(mk(4'h5));
        wait_num(1);
        rst_n = 1'b0;
        exp_q.delete();
        mat_q.delete();
        @(posedge clk_p); #1;
        check_val("midrst_valid_n", FW'(output_valid_n), FW'(1));
        check_val("midrst_num", FW'(num), FW'(0));
        check_val("midrst_slice", FW'(split_matrix), FW'(0));
        check_val("midrst_input_ready", FW'(input_ready), FW'(1));
        check_val("midrst_state", FW'(dbg_state), FW'(IDLE));
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk_p);
            check_val("post_rst_quiet", FW'(output_valid_n), FW'(1));
        end

        // Random matrices under random backpressure; the monitor reassembles each.
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) send_matrix(rand_mat());
                wait_idle();
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk_p); #1;
                    downstream_ready_n = 1'($urandom_range(0, 1));
                end
            end
        join
        downstream_ready_n = 1'b0;
        repeat (3) @(posedge clk_p);

        check_val("final_queue_empty", FW'(exp_q.size()), FW'(0));
        check_val("final_mat_empty", FW'(mat_q.size()), FW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/split_method1.md
Name: split_method1

Overview:
- Inverse of the head-merge stage in the attention op_trans path.
- Accepts one full merged matrix (SEQ_LEN x HEAD_NUM*HEAD_DIM) and replays it as COUNT_MAX = HEAD_NUM/HEAD_GROUP head-group slices, one slice per accepted transfer.
- Each slice carries its index `num` so a downstream per-head-group engine can process it.
- Slice k is the bit range [k*SLICE_W +: SLICE_W] of the merged matrix, which is the layout the merge stage produces.

Parameters:
- DATA_WIDTH, 8, bits per element.
- SEQ_LEN, 128, rows (merged shape dim 1).
- HEAD_GROUP, 4, heads per emitted slice (DSE-tunable).
- HEAD_DIM, 64, elements per head.
- HEAD_NUM, 12, total heads.
- NUM_WIDTH, 3, `num` is NUM_WIDTH+1 bits.

Ports:
- clk_p  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- matrix  in  DATA_WIDTH*SEQ_LEN*HEAD_NUM*HEAD_DIM  merged matrix.
- input_valid_n  in  1  active-low, `matrix` valid.
- input_ready  out  1  high when a new matrix can be accepted.
- downstream_ready_n  in  1  active-low, consumer accepts a slice this cycle.
- split_matrix  out  SLICE_W = DATA_WIDTH*SEQ_LEN*HEAD_GROUP*HEAD_DIM  current slice.
- num  out  NUM_WIDTH+1  index of current slice.
- output_valid_n  out  1  active-low, slice valid.
- output_last  out  1  high with final slice (num == COUNT_MAX-1).

Behaviour:
- Clock and reset: one clock, clk_p. Reset rst_n is synchronous and active-low.
- Elaboration checks (fatal error if violated):
  - HEAD_NUM % HEAD_GROUP == 0.
  - COUNT_MAX >= 1.
  - COUNT_MAX <= 2**(NUM_WIDTH+1).
- Reset: state IDLE, cnt=0, buffer=0. Outputs: split_matrix=0, num=0, output_valid_n=1, output_last=0, input_ready=1.
- Reset mid-split aborts the split; no further slices are emitted.
- FSM states: IDLE, SEND.
- IDLE:
  - input_ready=1 and output_valid_n=1.
  - On !input_valid_n: capture matrix into the full-width buffer, cnt<=0, go to SEND.
- SEND:
  - input_ready=0, and input_valid_n is ignored (no capture, no overwrite).
  - output_valid_n=0.
  - split_matrix = buffer[cnt*SLICE_W +: SLICE_W], num=cnt, output_last=(cnt==COUNT_MAX-1).
- Transfer: occurs in a SEND cycle with !downstream_ready_n.
  - Non-last slice: cnt<=cnt+1.
  - Last slice: cnt<=0 and go to IDLE; output_valid_n=1 the next cycle.
- Stall: while downstream_ready_n=1 in SEND, cnt, num and split_matrix hold stable. Valid must not drop.
- Latency: matrix accepted at edge T; slice 0 visible after T. Minimum COUNT_MAX+1 cycles per matrix (one IDLE accept cycle).
- COUNT_MAX==1: a single slice with output_last=1, then IDLE.
- Output timing:
  - input_ready is decoded from state only.
  - All other outputs are functions of registered state/cnt/buffer only, with no combinational path from any input.
- cnt is an unsigned register of width clog2(COUNT_MAX) (min 1); num is zero-extended from it.
- The buffer retains the last matrix after returning to IDLE. split_matrix may show slice 0 of it but is don't-care while output_valid_n=1.

Decomposition:
- Package split_merge_pkg holds:
  - function for COUNT_MAX = HEAD_NUM/HEAD_GROUP;
  - SLICE_W and FULL_W width functions;
  - state enum {IDLE, SEND};
  - shared with the merge stage so both agree on slice layout.
- The slice select (indexed part-select on buffer by cnt) is simple enough to stay inline.
- Optional sub-module split_slice_mux if synthesis of wide muxes is to be isolated.

Test Plan:
All scenarios use DATA_WIDTH=8, SEQ_LEN=2, HEAD_GROUP=2, HEAD_DIM=2, HEAD_NUM=6, giving SLICE_W=64 and COUNT_MAX=3. Slice k of matrix = 64'hk..k pattern.
- Basic: one matrix, downstream_ready_n=0 throughout -> three consecutive valid cycles.
  - num=0,1,2 with matching slices; output_last only on num=2.
  - Then output_valid_n=1 and input_ready=1.
- Backpressure: hold downstream_ready_n=1 for 4 cycles at num=1 -> split_matrix/num stable, output_valid_n=0; resumes with num=2 after release.
- Input during SEND: pulse input_valid_n=0 with a new matrix at num=1 -> ignored; remaining slices come from the original matrix.
- Back-to-back: new matrix presented continuously -> accepted in the single IDLE cycle after num=2; its slice 0 follows with one-cycle valid gap.
- Reset mid-split: rst_n=0 at num=1 -> next cycle output_valid_n=1, num=0, split_matrix=0, input_ready=1; no stale slices after release.
- Round trip: feed this block's slices into the merge stage -> merged output bit-exact to the original matrix.
